// File: rtl/audio_tone_sequencer.sv
// Note sequencer: plays {period, duration} entries from a small RAM into one
// channel of the audio generator, advancing on a divided-clock duration tick.
module audio_tone_sequencer #(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned TICK_DIV   = 25000,
   parameter int unsigned MUTETHRESH = 32
) (
   input  logic              clk25,
   input  logic              resetbutton_debounced,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [23:0]       wr_data,
   input  logic              start,
   input  logic              stop,
   input  logic              loop,
   output logic [15:0]       period_out,
   output logic              mute,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] cur_addr
);

   localparam int unsigned PW = $clog2(TICK_DIV + 1);
   localparam logic [PW-1:0]     PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StFetch, StPlay} state_t;

   state_t            state_q, state_d;
   logic [15:0]       period_q, period_d;
   logic              mute_q, mute_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [7:0]        rem_q, rem_d;
   logic [23:0]       mem [DEPTH];
   logic [23:0]       rd_q;
   logic              tick;

   // Read address is the next cur_addr so the entry is ready during FETCH;
   // non-blocking read gives read-before-write on a colliding write.
   always_ff @(posedge clk25) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_q <= mem[addr_d];
   end

   assign tick = (presc_q == PRESC_MAX);

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      done_d   = 1'b0;
      addr_d   = addr_q;
      presc_d  = presc_q;
      rem_d    = rem_q;
      unique case (state_q)
         StIdle: begin
            period_d = 16'h0000;
            if (start) begin
               state_d = StFetch;
               addr_d  = '0;
            end
         end
         StFetch: begin
            if (rd_q[7:0] == 8'd0) begin
               // End marker at entry 0 always terminates, even with loop set.
               if (loop && (addr_q != '0)) begin
                  addr_d = '0;
               end else begin
                  state_d  = StIdle;
                  done_d   = 1'b1;
                  period_d = 16'h0000;
               end
            end else begin
               state_d  = StPlay;
               period_d = rd_q[23:8];
               rem_d    = rd_q[7:0];
               presc_d  = '0;
            end
         end
         StPlay: begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
               rem_d = rem_q - 8'd1;
               if (rem_q == 8'd1) begin
                  if (addr_q != LAST_ADDR) begin
                     addr_d  = addr_q + ADDR_W'(1);
                     state_d = StFetch;
                  end else if (loop) begin
                     addr_d  = '0;
                     state_d = StFetch;
                  end else begin
                     state_d  = StIdle;
                     done_d   = 1'b1;
                     period_d = 16'h0000;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (stop) begin
         state_d  = StIdle;
         period_d = 16'h0000;
         done_d   = 1'b0;
         addr_d   = '0;
         presc_d  = '0;
         rem_d    = 8'd0;
      end
      mute_d = (period_d < 16'(MUTETHRESH));
   end

   always_ff @(posedge clk25 or negedge resetbutton_debounced) begin
      if (!resetbutton_debounced) begin
         state_q  <= StIdle;
         period_q <= 16'h0000;
         mute_q   <= 1'b1;
         done_q   <= 1'b0;
         addr_q   <= '0;
         presc_q  <= '0;
         rem_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         mute_q   <= mute_d;
         done_q   <= done_d;
         addr_q   <= addr_d;
         presc_q  <= presc_d;
         rem_q    <= rem_d;
      end
   end

   assign period_out = period_q;
   assign mute       = mute_q;
   assign busy       = (state_q != StIdle);
   assign done       = done_q;
   assign cur_addr   = addr_q;

endmodule

// File: tb/tb_audio_tone_sequencer.sv
// Directed bench for audio_tone_sequencer with a 4-cycle tick; t counts
// falling edges since start was presented, so t=k shows cycle T+k.
module tb_audio_tone_sequencer;

   logic        clk25 = 1'b0;
   logic        resetbutton_debounced;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [23:0] wr_data;
   logic        start, stop, loop;
   logic [15:0] period_out;
   logic        mute, busy, done;
   logic [3:0]  cur_addr;

   int checks = 0;
   int errors = 0;
   int t = 0;

   audio_tone_sequencer #(
      .DEPTH(16), .ADDR_W(4), .TICK_DIV(4), .MUTETHRESH(32)
   ) dut (
      .clk25                 (clk25),
      .resetbutton_debounced (resetbutton_debounced),
      .wr_en                 (wr_en),
      .wr_addr               (wr_addr),
      .wr_data               (wr_data),
      .start                 (start),
      .stop                  (stop),
      .loop                  (loop),
      .period_out            (period_out),
      .mute                  (mute),
      .busy                  (busy),
      .done                  (done),
      .cur_addr              (cur_addr)
   );

   always #5 clk25 = ~clk25;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s (t=%0d): observed %h expected %h", tag, t, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk25);
      t++;
   endtask

   task automatic goto(input int k);
      while (t < k) step();
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] p, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = {p, d};
      @(negedge clk25);
      wr_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; t = 0;
      step();
      start = 1'b0;
   endtask

   initial begin
      resetbutton_debounced = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; stop = 1'b0; loop = 1'b0;
      repeat (2) @(negedge clk25);
      chk("rst_period", period_out, 16'h0000);
      chk("rst_mute", mute, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_addr", cur_addr, 4'd0);
      resetbutton_debounced = 1'b1;
      @(negedge clk25);

      // 1: plain three-entry playback
      wr(4'd0, 16'h1000, 8'd3);
      wr(4'd1, 16'h0800, 8'd2);
      wr(4'd2, 16'hFFFF, 8'd0);
      pulse_start();
      chk("t1_fetch_busy", busy, 1'b1);
      chk("t1_fetch_period", period_out, 16'h0000);
      goto(2);  chk("t1_p0_first", period_out, 16'h1000); chk("t1_p0_mute", mute, 1'b0);
      goto(13); chk("t1_p0_last", period_out, 16'h1000);
      goto(14); chk("t1_fetch1_hold", period_out, 16'h1000); chk("t1_fetch1_addr", cur_addr, 4'd1);
      goto(15); chk("t1_p1_first", period_out, 16'h0800);
      goto(22); chk("t1_p1_last", period_out, 16'h0800);
      goto(23); chk("t1_nodone_early", done, 1'b0);
      goto(24); chk("t1_done", done, 1'b1); chk("t1_end_period", period_out, 16'h0000);
      chk("t1_end_mute", mute, 1'b1); chk("t1_end_busy", busy, 1'b0);
      goto(25); chk("t1_done_oneshot", done, 1'b0);

      // 2: looping, then loop cleared during entry1 of the second pass
      loop = 1'b1;
      pulse_start();
      goto(23); chk("t2_marker_fetch", busy, 1'b1);
      goto(24); chk("t2_no_done", done, 1'b0); chk("t2_refetch_addr", cur_addr, 4'd0);
      goto(25); chk("t2_wrap_p0", period_out, 16'h1000);
      goto(38); chk("t2_second_p1", period_out, 16'h0800);
      goto(40); loop = 1'b0;
      goto(46); chk("t2_nodone_46", done, 1'b0);
      goto(47); chk("t2_done", done, 1'b1); chk("t2_end_busy", busy, 1'b0);
      goto(48); chk("t2_done_oneshot", done, 1'b0);

      // 3: stop during entry0; then start+stop together from idle
      pulse_start();
      goto(6); stop = 1'b1;
      step(); stop = 1'b0;
      chk("t3_stop_period", period_out, 16'h0000);
      chk("t3_stop_busy", busy, 1'b0);
      chk("t3_stop_addr", cur_addr, 4'd0);
      chk("t3_stop_mute", mute, 1'b1);
      for (int i = 0; i < 20; i++) begin
         chk("t3_no_done", done, 1'b0);
         step();
      end
      start = 1'b1; stop = 1'b1;
      step(); start = 1'b0; stop = 1'b0;
      chk("t3_both_idle", busy, 1'b0);
      step(); chk("t3_both_idle2", busy, 1'b0);

      // 4: rest entry and threshold boundary
      wr(4'd0, 16'h0010, 8'd2);
      wr(4'd1, 16'h0020, 8'd1);
      wr(4'd2, 16'h0000, 8'd0);
      pulse_start();
      goto(2);  chk("t4_rest_period", period_out, 16'h0010); chk("t4_rest_mute", mute, 1'b1);
      chk("t4_rest_busy", busy, 1'b1);
      goto(11); chk("t4_p1_period", period_out, 16'h0020); chk("t4_p1_mute", mute, 1'b0);
      goto(16); chk("t4_done", done, 1'b1);

      // 5: end marker at entry 0 with loop set terminates
      wr(4'd0, 16'h1234, 8'd0);
      loop = 1'b1;
      pulse_start();
      chk("t5_busy_t1", busy, 1'b1);
      goto(2); chk("t5_done", done, 1'b1); chk("t5_busy_t2", busy, 1'b0);
      chk("t5_period", period_out, 16'h0000);
      goto(3); chk("t5_done_oneshot", done, 1'b0); chk("t5_idle", busy, 1'b0);
      loop = 1'b0;

      // 6: all 16 entries, last entry ends without wrap; then async reset mid-play
      for (int i = 0; i < 16; i++) wr(4'(i), 16'h0100 + 16'(i), 8'd1);
      pulse_start();
      for (int i = 0; i < 16; i++) begin
         goto(2 + 5 * i);
         chk("t6_addr", cur_addr, 32'(i));
         chk("t6_period", period_out, 32'h0100 + 32'(i));
      end
      goto(80); chk("t6_nodone_80", done, 1'b0);
      goto(81); chk("t6_done", done, 1'b1); chk("t6_end_busy", busy, 1'b0);
      chk("t6_end_period", period_out, 16'h0000);
      pulse_start();
      goto(37); chk("t6b_addr7", cur_addr, 4'd7);
      #1 resetbutton_debounced = 1'b0;
      #1;
      chk("t6b_rst_period", period_out, 16'h0000);
      chk("t6b_rst_mute", mute, 1'b1);
      chk("t6b_rst_busy", busy, 1'b0);
      chk("t6b_rst_done", done, 1'b0);
      chk("t6b_rst_addr", cur_addr, 4'd0);
      step();
      resetbutton_debounced = 1'b1;
      step(); step();
      chk("t6b_post_idle", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
